// File: rtl/address_filter_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : address_filter_multi_pkg
// Brief    : Shared constants, state type and byte-select helper for the
//            multi-entry destination-address filter.
// Revision : 1.0 - initial release
// ============================================================================
package address_filter_multi_pkg;

    localparam int         MAC_BYTES  = 6;
    localparam int         CNT_W      = 3;
    localparam logic [7:0] BCAST_BYTE = 8'hFF;

    localparam logic [1:0] MT_NONE    = 2'd0;
    localparam logic [1:0] MT_UCAST   = 2'd1;
    localparam logic [1:0] MT_GROUP   = 2'd2;
    localparam logic [1:0] MT_PROMISC = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DECIDE  = 2'd2
    } state_t;

    // Byte 0 is the most significant byte of the 48-bit address.
    function automatic logic [7:0] mac_byte(input logic [47:0] addr, input logic [CNT_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = addr[47:40];
            3'd1:    b = addr[39:32];
            3'd2:    b = addr[31:24];
            3'd3:    b = addr[23:16];
            3'd4:    b = addr[15:8];
            3'd5:    b = addr[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/address_filter_multi_entry_cmp.sv
`default_nettype none
// ============================================================================
// Module   : mac_addr_entry_cmp
// Brief    : One table entry: compares the current address byte and keeps a
//            running hit flag across the six bytes of a frame.
// Revision : 1.0 - initial release
// ============================================================================
module mac_addr_entry_cmp
    import address_filter_multi_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_go,
    input  logic             i_accept,
    input  logic             i_en,
    input  logic [47:0]      i_entry,
    input  logic [CNT_W-1:0] i_sel,
    input  logic [7:0]       i_data,
    output logic             o_hit_next
);

    logic w_eq;
    logic r_hit;

    assign w_eq       = (i_data == mac_byte(i_entry, i_sel));
    assign o_hit_next = r_hit & w_eq;

    // Gating the initial flag with the enable captures it for the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit <= 1'b0;
        end else if (i_go) begin
            r_hit <= i_en & w_eq;
        end else if (i_accept) begin
            r_hit <= r_hit & w_eq;
        end
    end

endmodule
`default_nettype wire

// File: rtl/address_filter_multi.sv
`default_nettype none
// ============================================================================
// Module   : address_filter_multi
// Brief    : Destination-address filter with NUM_ADDR unicast entries plus
//            broadcast, multicast and promiscuous acceptance.
// Revision : 1.0 - initial release
// ============================================================================
module address_filter_multi
    import address_filter_multi_pkg::*;
#(
    parameter int NUM_ADDR = 4,
    parameter int IDX_W    = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic [7:0]            data,
    input  logic                  data_valid,
    input  logic [48*NUM_ADDR-1:0] addr_table,
    input  logic [NUM_ADDR-1:0]   addr_en,
    input  logic                  cfg_promisc,
    input  logic                  cfg_bcast,
    input  logic                  cfg_mcast,
    output logic                  done,
    output logic                  match,
    output logic [1:0]            match_type,
    output logic [IDX_W-1:0]      match_idx
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_bcast;
    logic               r_group;
    logic               r_cfg_promisc;
    logic               r_cfg_bcast;
    logic               r_cfg_mcast;

    logic               w_accept;
    logic               w_last;
    logic [CNT_W-1:0]   w_sel;
    logic [NUM_ADDR-1:0] w_hit_next;
    logic               w_any;
    logic [IDX_W-1:0]   w_idx;
    logic               w_bcast_final;
    logic [1:0]         w_type;

    assign w_accept = (r_state == S_COLLECT) && data_valid && !go;
    assign w_last   = w_accept && (r_cnt == CNT_W'(MAC_BYTES - 1));
    assign w_sel    = go ? '0 : r_cnt;

    generate
        for (genvar k = 0; k < NUM_ADDR; k++) begin : g_entry
            mac_addr_entry_cmp u_cmp (
                .clk        (clk),
                .rst        (reset),
                .i_go       (go),
                .i_accept   (w_accept),
                .i_en       (addr_en[k]),
                .i_entry    (addr_table[48*k +: 48]),
                .i_sel      (w_sel),
                .i_data     (data),
                .o_hit_next (w_hit_next[k])
            );
        end
    endgenerate

    // Final-byte decision: flags already folded with the byte being accepted.
    always_comb begin
        w_any = |w_hit_next;
        w_idx = '0;
        for (int k = NUM_ADDR - 1; k >= 0; k--) begin
            if (w_hit_next[k]) begin
                w_idx = IDX_W'(k);
            end
        end
    end

    assign w_bcast_final = r_bcast && (data == BCAST_BYTE);

    always_comb begin
        w_type = MT_NONE;
        if (w_any) begin
            w_type = MT_UCAST;
        end else if (r_cfg_bcast && w_bcast_final) begin
            w_type = MT_GROUP;
        end else if (r_cfg_mcast && r_group && !w_bcast_final) begin
            w_type = MT_GROUP;
        end else if (r_cfg_promisc) begin
            w_type = MT_PROMISC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_bcast       <= 1'b0;
            r_group       <= 1'b0;
            r_cfg_promisc <= 1'b0;
            r_cfg_bcast   <= 1'b0;
            r_cfg_mcast   <= 1'b0;
            done          <= 1'b0;
            match         <= 1'b0;
            match_type    <= MT_NONE;
            match_idx     <= '0;
        end else begin
            done       <= 1'b0;
            match      <= 1'b0;
            match_type <= MT_NONE;
            match_idx  <= '0;
            if (go) begin
                r_state       <= S_COLLECT;
                r_cnt         <= CNT_W'(1);
                r_bcast       <= (data == BCAST_BYTE);
                r_group       <= data[0];
                r_cfg_promisc <= cfg_promisc;
                r_cfg_bcast   <= cfg_bcast;
                r_cfg_mcast   <= cfg_mcast;
            end else begin
                case (r_state)
                    S_COLLECT: begin
                        if (data_valid) begin
                            r_cnt   <= r_cnt + CNT_W'(1);
                            r_bcast <= w_bcast_final;
                            if (w_last) begin
                                r_state    <= S_DECIDE;
                                done       <= 1'b1;
                                match      <= (w_type != MT_NONE);
                                match_type <= w_type;
                                match_idx  <= w_any ? w_idx : '0;
                            end
                        end
                    end
                    S_DECIDE: r_state <= S_IDLE;
                    default:  r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_address_filter_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_address_filter_multi
// Brief    : Self-checking bench: directed frames plus random frames compared
//            against a whole-address reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_address_filter_multi;

    localparam int N     = 4;
    localparam int IDX_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              go;
    logic [7:0]        data;
    logic              data_valid;
    logic [48*N-1:0]   tbl;
    logic [N-1:0]      addr_en;
    logic              cfg_promisc;
    logic              cfg_bcast;
    logic              cfg_mcast;
    logic              done;
    logic              match;
    logic [1:0]        match_type;
    logic [IDX_W-1:0]  match_idx;

    int n_vec    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = -100;
    logic             last_match;
    logic [1:0]       last_type;
    logic [IDX_W-1:0] last_idx;

    always #5 clk = ~clk;

    address_filter_multi #(.NUM_ADDR(N), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .data        (data),
        .data_valid  (data_valid),
        .addr_table  (tbl),
        .addr_en     (addr_en),
        .cfg_promisc (cfg_promisc),
        .cfg_bcast   (cfg_bcast),
        .cfg_mcast   (cfg_mcast),
        .done        (done),
        .match       (match),
        .match_type  (match_type),
        .match_idx   (match_idx)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decision from the whole 48-bit address.
    function automatic void model(input logic [47:0] a, input logic [48*N-1:0] t,
                                  input logic [N-1:0] en, input logic p, input logic b,
                                  input logic m, output logic em, output logic [1:0] et,
                                  output logic [IDX_W-1:0] ei);
        int hit = -1;
        et = 2'd0;
        ei = '0;
        for (int k = N - 1; k >= 0; k--)
            if (en[k] && t[48*k +: 48] == a) hit = k;
        if (hit >= 0) begin
            et = 2'd1;
            ei = IDX_W'(hit);
        end else if (b && a == 48'hFFFF_FFFF_FFFF) et = 2'd2;
        else if (m && a[40] && a != 48'hFFFF_FFFF_FFFF) et = 2'd2;
        else if (p) et = 2'd3;
        em = (et != 2'd0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc   = cyc;
            last_match = match;
            last_type  = match_type;
            last_idx   = match_idx;
        end else begin
            check_eq("outs_zero_without_done", 64'({match, match_type, match_idx}), 64'd0);
        end
    endtask

    task automatic send_partial(input logic [47:0] a, input int nb);
        go = 1'b1;
        data = a[47:40];
        data_valid = 1'b1;
        tick();
        go = 1'b0;
        for (int b = 1; b < nb; b++) begin
            data = a[8*(5-b) +: 8];
            tick();
        end
        data_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] a, input int spos, input int slen,
                              input bit rnd, input bit scr, output int st);
        int n;
        st = 0;
        go = 1'b1;
        data = a[47:40];
        data_valid = 1'($urandom);
        tick();
        go = 1'b0;
        if (scr) begin
            cfg_promisc = 1'($urandom);
            cfg_bcast   = 1'($urandom);
            cfg_mcast   = 1'($urandom);
            addr_en     = N'($urandom);
        end
        for (int b = 1; b < 6; b++) begin
            n = (b == spos) ? slen : (rnd ? int'($urandom_range(0, 2)) : 0);
            st += n;
            repeat (n) begin
                data_valid = 1'b0;
                data = 8'($urandom);
                tick();
            end
            data_valid = 1'b1;
            data = a[8*(5-b) +: 8];
            tick();
        end
        data_valid = 1'b0;
    endtask

    task automatic frame_check(input string tag, input logic [47:0] a, input int spos,
                               input int slen, input bit rnd, input bit scr);
        logic             em;
        logic [1:0]       et;
        logic [IDX_W-1:0] ei;
        int d0, t, st;
        model(a, tbl, addr_en, cfg_promisc, cfg_bcast, cfg_mcast, em, et, ei);
        d0 = done_cnt;
        t  = cyc;
        send_frame(a, spos, slen, rnd, scr, st);
        tick();
        tick();
        check_eq({tag, "_ndone"}, 64'(done_cnt - d0), 64'd1);
        check_eq({tag, "_latency"}, 64'(done_cyc - t), 64'(6 + st));
        check_eq({tag, "_match"}, 64'(last_match), 64'(em));
        check_eq({tag, "_type"}, 64'(last_type), 64'(et));
        check_eq({tag, "_idx"}, 64'(last_idx), 64'(ei));
    endtask

    task automatic idle_noise();
        int d0 = done_cnt;
        repeat (4) begin
            data_valid = 1'b1;
            data = 8'($urandom);
            tick();
        end
        data_valid = 1'b0;
        check_eq("idle_ignore", 64'(done_cnt - d0), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] a;
        int d0, i, j, sel;

        reset = 1'b1; go = 1'b0; data = 8'h00; data_valid = 1'b0;
        cfg_promisc = 1'b0; cfg_bcast = 1'b0; cfg_mcast = 1'b0; addr_en = '0;
        for (int k = 0; k < N; k++) tbl[48*k +: 48] = {16'($urandom), $urandom()} & 48'hFEFF_FFFF_FFFF;
        repeat (3) tick();
        check_eq("reset_done", 64'(done), 64'd0);
        check_eq("reset_match", 64'(match), 64'd0);
        check_eq("reset_type", 64'(match_type), 64'd0);
        check_eq("reset_idx", 64'(match_idx), 64'd0);
        reset = 1'b0;
        tick();

        tbl[48*2 +: 48] = 48'h0050_C212_3456;
        addr_en = 4'hF;
        frame_check("ucast_e2", 48'h0050_C212_3456, 0, 0, 0, 0);
        check_eq("ucast_e2_type_c", 64'(last_type), 64'd1);
        check_eq("ucast_e2_idx_c", 64'(last_idx), 64'd2);

        cfg_bcast = 1'b1;
        frame_check("bcast_on", 48'hFFFF_FFFF_FFFF, 0, 0, 0, 0);
        check_eq("bcast_on_type_c", 64'(last_type), 64'd2);
        cfg_bcast = 1'b0;
        frame_check("bcast_off", 48'hFFFF_FFFF_FFFF, 0, 0, 0, 0);
        check_eq("bcast_off_match_c", 64'(last_match), 64'd0);

        cfg_mcast = 1'b1;
        frame_check("mcast", 48'h0100_5E00_0001, 0, 0, 0, 0);
        check_eq("mcast_type_c", 64'(last_type), 64'd2);
        cfg_mcast = 1'b0; cfg_promisc = 1'b1;
        frame_check("promisc", 48'h0100_5E00_0001, 0, 0, 0, 0);
        check_eq("promisc_type_c", 64'(last_type), 64'd3);
        cfg_promisc = 1'b0;

        frame_check("stall_e1", tbl[48*1 +: 48], 3, 3, 0, 0);
        check_eq("stall_e1_idx_c", 64'(last_idx), 64'd1);

        addr_en = 4'h0;
        frame_check("all_disabled", 48'h0050_C212_3456, 0, 0, 0, 0);
        addr_en = 4'hF;

        tbl[48*3 +: 48] = tbl[48*1 +: 48];
        frame_check("dup_lowest", tbl[48*1 +: 48], 0, 0, 1, 0);

        d0 = done_cnt;
        send_partial(tbl[48*0 +: 48], 4);
        frame_check("abort", 48'h0050_C212_3456, 0, 0, 0, 0);
        check_eq("abort_total_done", 64'(done_cnt - d0), 64'd1);

        d0 = done_cnt;
        send_partial(48'h0050_C212_3456, 3);
        reset = 1'b1; go = 1'b1; data_valid = 1'b1; data = 8'h00;
        tick();
        reset = 1'b0; go = 1'b0;
        check_eq("mid_reset_outs", 64'({done, match, match_type, match_idx}), 64'd0);
        for (int b = 1; b < 6; b++) begin
            data = 8'h50;
            tick();
        end
        data_valid = 1'b0;
        tick();
        check_eq("mid_reset_no_done", 64'(done_cnt - d0), 64'd0);
        frame_check("after_reset", 48'h0050_C212_3456, 0, 0, 0, 0);

        idle_noise();

        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                i = int'($urandom_range(0, N - 1));
                j = int'($urandom_range(0, N - 1));
                tbl[48*j +: 48] = tbl[48*i +: 48];
            end
            addr_en     = N'($urandom);
            cfg_promisc = 1'($urandom);
            cfg_bcast   = 1'($urandom);
            cfg_mcast   = 1'($urandom);
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       a = tbl[48*$urandom_range(0, N - 1) +: 48];
                1:       a = 48'hFFFF_FFFF_FFFF;
                2:       a = {16'($urandom), $urandom()} | 48'h0100_0000_0000;
                default: a = {16'($urandom), $urandom()};
            endcase
            frame_check("rand", a, 0, 0, 1, 1);
            if (f % 10 == 0) idle_noise();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
